// File: rtl/dsp_ctrl_pkg.sv
// Shared definitions for the audio DSP mode controller: path-select mode
// codes, sequencer state encoding and the mode normalisation helper.
package dsp_ctrl_pkg;

  localparam logic [1:0] MODE_FIR      = 2'd0;
  localparam logic [1:0] MODE_ECHO     = 2'd1;
  localparam logic [1:0] MODE_STRAIGHT = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FADE_OUT = 2'd1,
    ST_SWITCH   = 2'd2,
    ST_FADE_IN  = 2'd3
  } seq_state_e;

  // Code 3 has no path of its own; it aliases the straight-through path.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_STRAIGHT : m;
  endfunction

endpackage

// File: rtl/sample_gain_scaler.sv
// Registered gain stage: on each enabled cycle the signed sample is scaled by
// an unsigned gain and arithmetically shifted right, keeping the low 16 bits.
module sample_gain_scaler #(
  parameter int GAIN_W = 5,
  parameter int SHIFT  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en_i,
  input  logic [15:0]       sample_i,
  input  logic [GAIN_W-1:0] gain_i,
  output logic [15:0]       sample_o
);

  // One extra bit so the zero-extended gain is non-negative as a signed value.
  localparam int PW = 16 + GAIN_W + 1;

  logic signed [PW-1:0] sample_ext;
  logic signed [PW-1:0] gain_ext;
  logic signed [PW-1:0] prod;
  logic [15:0]          sample_d;
  logic [15:0]          sample_q;

  // Signed multiply and arithmetic shift; gain never exceeds 2**SHIFT.
  always_comb begin
    sample_ext = PW'($signed(sample_i));
    gain_ext   = PW'({1'b0, gain_i});
    prod       = sample_ext * gain_ext;
    sample_d   = 16'(prod >>> SHIFT);
  end

  // Output register advances only on sample strobes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sample_q <= 16'd0;
    end else if (en_i) begin
      sample_q <= sample_d;
    end
  end

  assign sample_o = sample_q;

endmodule

// File: rtl/dsp_mode_sequencer.sv
// Click-free mode controller: fades the current path to silence, switches the
// path selector while muted, then fades the new path back in.
// Handshake: req_ready is high exactly while in RUN; a request is taken on any
// cycle with req_valid && req_ready, and is dropped (not queued) otherwise.
module dsp_mode_sequencer
  import dsp_ctrl_pkg::*;
#(
  parameter int RAMP_LEN   = 16,
  parameter int RAMP_LOG2  = 4,
  parameter int RESET_MODE = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sample_tick,
  input  logic               req_valid,
  input  logic [1:0]         req_mode,
  output logic               req_ready,
  output logic [1:0]         selector,
  input  logic [15:0]        path_sample,
  output logic [15:0]        out_sample,
  output logic               busy,
  output logic [1:0]         dbg_state_o,
  output logic [RAMP_LOG2:0] dbg_gain_o
);

  localparam int               GW      = RAMP_LOG2 + 1;
  localparam logic [GW-1:0]    FULL    = GW'(RAMP_LEN);
  localparam logic [1:0]       RST_SEL = norm_mode(2'(RESET_MODE));

  seq_state_e    state_q, state_d;
  logic [GW-1:0] gain_q, gain_d;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    pend_q, pend_d;
  logic [1:0]    req_mode_n;

  // State, gain, selector and pending-mode registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      gain_q  <= FULL;
      sel_q   <= RST_SEL;
      pend_q  <= RST_SEL;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state logic; gain and selector move only on sample strobes.
  always_comb begin
    state_d    = state_q;
    gain_d     = gain_q;
    sel_d      = sel_q;
    pend_d     = pend_q;
    req_mode_n = norm_mode(req_mode);
    req_ready  = (state_q == ST_RUN);
    case (state_q)
      ST_RUN: begin
        gain_d = FULL;
        if (req_valid && (req_mode_n != sel_q)) begin
          pend_d  = req_mode_n;
          state_d = ST_FADE_OUT;
        end
      end
      ST_FADE_OUT: begin
        if (sample_tick) begin
          gain_d = gain_q - GW'(1);
          if (gain_q == GW'(1)) state_d = ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        if (sample_tick) begin
          sel_d   = pend_q;
          state_d = ST_FADE_IN;
        end
      end
      ST_FADE_IN: begin
        if (sample_tick) begin
          gain_d = gain_q + GW'(1);
          if (gain_q == FULL - GW'(1)) state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  sample_gain_scaler #(
    .GAIN_W (GW),
    .SHIFT  (RAMP_LOG2)
  ) u_scaler (
    .clock    (clock),
    .reset    (reset),
    .en_i     (sample_tick),
    .sample_i (path_sample),
    .gain_i   (gain_q),
    .sample_o (out_sample)
  );

  assign selector    = sel_q;
  assign busy        = (state_q != ST_RUN);
  assign dbg_state_o = state_q;
  assign dbg_gain_o  = gain_q;

endmodule

// File: tb/tb_dsp_mode_sequencer.sv
// Bench for dsp_mode_sequencer: one instance with a 4-sample ramp and one with
// a 16-sample ramp, driven one at a time against a tick-schedule model.
module tb_dsp_mode_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // Ramp-length-4 instance
  logic        tk4 = 0, rv4 = 0;
  logic [1:0]  rm4 = 0;
  logic [15:0] ps4 = 0;
  logic        rdy4, busy4;
  logic [1:0]  sel4, st4;
  logic [15:0] out4;
  logic [2:0]  g4;

  // Ramp-length-16 instance
  logic        tk16 = 0, rv16 = 0;
  logic [1:0]  rm16 = 0;
  logic [15:0] ps16 = 0;
  logic        rdy16, busy16;
  logic [1:0]  sel16, st16;
  logic [15:0] out16;
  logic [4:0]  g16;

  dsp_mode_sequencer #(.RAMP_LEN(4), .RAMP_LOG2(2), .RESET_MODE(2)) dut4 (
    .clock(clock), .reset(reset), .sample_tick(tk4), .req_valid(rv4),
    .req_mode(rm4), .req_ready(rdy4), .selector(sel4), .path_sample(ps4),
    .out_sample(out4), .busy(busy4), .dbg_state_o(st4), .dbg_gain_o(g4));

  dsp_mode_sequencer #(.RAMP_LEN(16), .RAMP_LOG2(4), .RESET_MODE(2)) dut16 (
    .clock(clock), .reset(reset), .sample_tick(tk16), .req_valid(rv16),
    .req_mode(rm16), .req_ready(rdy16), .selector(sel16), .path_sample(ps16),
    .out_sample(out16), .busy(busy16), .dbg_state_o(st16), .dbg_gain_o(g16));

  // Observed outputs of whichever instance is active
  logic        cur = 1'b0;
  logic        o_ready, o_busy;
  logic [1:0]  o_sel;
  logic [15:0] o_out;
  logic [4:0]  o_gain;
  assign o_ready = cur ? rdy16 : rdy4;
  assign o_busy  = cur ? busy16 : busy4;
  assign o_sel   = cur ? sel16 : sel4;
  assign o_out   = cur ? out16 : out4;
  assign o_gain  = cur ? g16 : {2'b00, g4};

  int checks = 0;
  int errors = 0;
  int busy_ticks = 0;

  // Reference model: a pending mode change is a queue of the gain in force at
  // each of its upcoming ticks; an empty queue means the block is idle.
  int          ml, mlog;
  int          gq[$];
  logic [1:0]  m_sel, m_pend;
  int          m_ticks;
  logic [15:0] m_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    gq.delete();
    m_sel   = 2'd2;
    m_pend  = 2'd2;
    m_out   = 16'd0;
    m_ticks = 0;
  endtask

  task automatic model_edge(input logic tk, input logic rv, input logic [1:0] rm,
                            input logic [15:0] ps);
    bit idle;
    int g, s, p, q, nm;
    idle = (gq.size() == 0);
    g    = idle ? ml : gq[0];
    if (tk) begin
      s = int'($signed(ps));
      p = s * g;
      q = p >>> mlog;
      m_out = q[15:0];
      if (!idle) begin
        void'(gq.pop_front());
        m_ticks++;
        if (m_ticks == ml + 1) m_sel = m_pend;
      end
    end
    if (idle && rv) begin
      nm = (rm == 2'd3) ? 2 : int'(rm);
      if (nm != int'(m_sel)) begin
        m_pend  = nm[1:0];
        m_ticks = 0;
        for (int k = ml; k >= 0; k--) gq.push_back(k);
        for (int k = 0; k < ml; k++) gq.push_back(k);
      end
    end
  endtask

  // One clock: drive at the falling edge, check ready, clock, check outputs.
  task automatic step(input logic tk, input logic rv, input logic [1:0] rm,
                      input logic [15:0] ps);
    logic [1:0] prev_sel;
    if (cur) begin
      tk16 = tk; rv16 = rv; rm16 = rm; ps16 = ps;
      tk4 = 0; rv4 = 0; rm4 = 0; ps4 = 0;
    end else begin
      tk4 = tk; rv4 = rv; rm4 = rm; ps4 = ps;
      tk16 = 0; rv16 = 0; rm16 = 0; ps16 = 0;
    end
    #1;
    check("req_ready", o_ready, (gq.size() == 0));
    if (tk && o_busy) busy_ticks++;
    prev_sel = o_sel;
    @(posedge clock);
    model_edge(tk, rv, rm, ps);
    @(negedge clock);
    check("out_sample", o_out, m_out);
    check("selector", o_sel, m_sel);
    check("busy", o_busy, (gq.size() != 0));
    check("gain", o_gain, (gq.size() != 0) ? gq[0] : ml);
    if (o_sel != prev_sel) check("sel_silent", o_gain, 0);
  endtask

  task automatic do_reset(input logic which, input int l, input int lg);
    @(negedge clock);
    cur = which;
    reset = 1'b0;
    tk4 = 0; rv4 = 0; tk16 = 0; rv16 = 0;
    ml = l; mlog = lg;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_sel", o_sel, 2);
    check("rst_ready", o_ready, 1);
    check("rst_busy", o_busy, 0);
    check("rst_gain", o_gain, l);
    check("rst_out", o_out, 0);
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++)
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
           2'($urandom_range(0, 3)), 16'($urandom));
  endtask

  logic [15:0] seq[10];
  logic [15:0] exp_seq[10];

  initial begin
    exp_seq = '{16'h0400, 16'h0300, 16'h0200, 16'h0100, 16'h0000,
                16'h0000, 16'h0100, 16'h0200, 16'h0300, 16'h0400};

    // ---- Ramp length 4 ----
    ps4 = 16'h1234;
    do_reset(1'b0, 4, 2);
    step(1, 0, 0, 16'h1234);
    check("first_tick_out", o_out, 16'h1234);

    // Mode change straight -> FIR with ticks spaced by idle clocks
    step(0, 1, 0, 16'h0400);
    busy_ticks = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 16'h0400);
      seq[i] = o_out;
      step(0, 0, 0, 16'h0400);
      step(0, 0, 0, 16'h0400);
    end
    for (int i = 0; i < 10; i++) check("fade_seq", seq[i], exp_seq[i]);
    check("busy_span", busy_ticks, 9);
    check("sel_after_change", o_sel, 0);

    // Negative full-scale sample at gain 2
    step(1, 1, 2, 16'h8000);
    step(1, 0, 0, 16'h8000);
    step(1, 0, 0, 16'h8000);
    step(1, 0, 0, 16'h8000);
    check("neg_gain2", o_out, 16'hC000);
    for (int i = 0; i < 20 && o_busy; i++) step(1, 0, 0, 16'($urandom));
    check("back_to_straight", o_sel, 2);

    // Alias code 3 while straight: accepted as a no-op
    step(0, 1, 3, 16'h0100);
    step(1, 0, 0, 16'h0100);
    check("alias_noop_busy", o_busy, 0);

    // Request during FADE_IN is ignored
    step(0, 1, 0, 16'h0200);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 16'h0200);
    step(1, 1, 1, 16'h0200);
    for (int i = 0; i < 20 && o_busy; i++) step(1, 0, 0, 16'h0200);
    check("ignored_req_sel", o_sel, 0);

    // Reset asserted mid-fade at gain 2
    step(0, 1, 2, 16'h0300);
    step(1, 0, 0, 16'h0300);
    step(1, 0, 0, 16'h0300);
    check("pre_reset_gain", o_gain, 2);
    reset = 1'b0;
    #1;
    model_reset();
    check("midfade_sel", o_sel, 2);
    check("midfade_gain", o_gain, 4);
    check("midfade_busy", o_busy, 0);
    @(negedge clock);
    reset = 1'b1;
    step(1, 0, 0, 16'h0300);

    run_random(400);

    // ---- Ramp length 16 ----
    do_reset(1'b1, 16, 4);
    step(1, 0, 0, 16'h7FFF);
    check("full_scale", o_out, 16'h7FFF);
    step(0, 1, 1, 16'h1000);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 16'h1000);
    for (int i = 0; i < 1000; i++) step(0, 0, 0, 16'($urandom));
    check("gap_gain", o_gain, 11);
    check("gap_busy", o_busy, 1);
    for (int i = 0; i < 40 && o_busy; i++) step(1, 0, 0, 16'h1000);
    check("gap_done_sel", o_sel, 1);
    check("gap_done_busy", o_busy, 0);

    run_random(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
